mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters: the fetch stage (driven from pc_reg.pc) and the data-memory stage.
- Issues one transaction at a time and tracks its fixed read latency.
- Returns data or a write-ack to whichever requester owns the transaction.
- Generates stall signals to freeze the PC and data stage while they wait.
- Data requests have priority; a bounded starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; must be >= 1
- STARVE_MAX, 4, lost arbitrations after which fetch gets priority; must be >= 1

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid this cycle
- if_rdata  out  DATA_W  fetch data
- dm_req  in  1  data request
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  read data valid, or write-ack
- dm_rdata  out  DATA_W  read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- stall_if  out  1  hold PC / fetch stage
- stall_dm  out  1  hold data stage

Behaviour:
- State machine states:
  - IDLE: no transaction outstanding.
  - BUSY: one transaction outstanding. Owner register holds IF or DM; latency counter lat_cnt is $clog2(MEM_LAT+1) bits.
- Grant window: the arbiter can grant when the state is IDLE, or when it is BUSY and lat_cnt == MEM_LAT (the completion cycle). Back-to-back throughput is therefore one access per MEM_LAT cycles.
- Arbitration in a grant window:
  - If starve_cnt == STARVE_MAX and if_req is high, IF wins.
  - Otherwise, if dm_req is high, DM wins.
  - Otherwise, if if_req is high, IF wins.
  - Only one gnt is asserted per cycle.
- Grant outputs are combinational:
  - gnt = mem_en = 1 in the grant cycle.
  - mem_addr, mem_we and mem_wdata are muxed from the winner; mem_we = dm_we & dm_gnt.
  - When mem_en = 0, all mem_* outputs are 0.
- On grant:
  - state becomes BUSY, owner is set to the winner, lat_cnt is set to 1.
  - While BUSY, lat_cnt increments each cycle until it reaches MEM_LAT.
- Completion cycle (BUSY and lat_cnt == MEM_LAT):
  - The owner's rvalid = 1, and its rdata = mem_rdata (combinational passthrough).
  - For a DM write, dm_rvalid is asserted as an ack and dm_rdata is don't-care.
  - If there is no new grant in this cycle, state becomes IDLE.
- Non-owner rdata outputs are 0.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on every grant to DM while if_req = 1.
  - Clears on every IF grant.
- Handshake rules:
  - A requester keeps req and its address/data stable until gnt.
  - Dropping req before gnt is legal: no access is made and nothing is recorded.
  - Requests presented in the cycle that is granted are not re-sampled afterwards.
- Stall outputs:
  - stall_if = (if_req & ~if_gnt) | (BUSY & owner == IF & ~if_rvalid).
  - stall_dm is defined the same way for DM.
- Reset (reset == 0, sampled on a clock edge):
  - state = IDLE, owner = IF, lat_cnt = 0, starve_cnt = 0.
  - All outputs are driven 0 while reset is low, including gnt, rvalid, mem_en and stalls.
  - A reset during BUSY abandons the transaction; no rvalid is ever produced for it.
- In the first cycle after reset releases, requests are arbitrated normally.

Decomposition:
- Shared package proc_pkg holds:
  - state enum (IDLE, BUSY)
  - owner enum (OWN_IF, OWN_DM)
  - default ADDR_W/DATA_W constants
- One natural sub-module: mem_lat_timer (lat_cnt load/increment/done flag, parameterised by MEM_LAT).
- Arbitration and muxing stay in the top module.

Test Plan (MEM_LAT=2, STARVE_MAX=4, reset released before cycle 0):
- IF-only read:
  - Stimulus: if_req=1, if_addr=0x0 at cycle 1; memory returns 0x00000013.
  - Response: if_gnt=mem_en=1 and mem_addr=0x0 at cycle 1; stall_if=1 at cycle 2; if_rvalid=1 with if_rdata=0x00000013 at cycle 3.
- Simultaneous requests:
  - Stimulus: if_req=dm_req=1, dm_addr=0x100 at cycle 1.
  - Response: dm_gnt at 1; dm_rvalid and if_gnt at 3; if_rvalid at 5; starve_cnt=1 at cycle 2.
- Starvation:
  - Stimulus: dm_req and if_req held high continuously.
  - Response: DM granted at cycles 1, 3, 5, 7; IF granted at cycle 9; DM granted again at cycle 11.
- Back-to-back fetch:
  - Stimulus: if_addr = 0x0, 0x4, 0x8 presented as each grant occurs.
  - Response: grants at cycles 1, 3, 5; if_rvalid at 3, 5, 7; no idle cycle between grants.
- Write and abandoned request:
  - Stimulus: dm_we=1, dm_addr=0x200, dm_wdata=0xDEADBEEF at cycle 1; then if_req pulsed for one cycle at cycle 2 and dropped.
  - Response: mem_we=1 with correct data at cycle 1; dm_rvalid at 3; no IF grant and no mem_en at cycles 2-4.
- Reset mid-operation:
  - Stimulus: IF granted at cycle 1; reset=0 at cycle 2 for 2 cycles.
  - Response: no if_rvalid at cycle 3; all outputs 0 during reset; a fresh if_req after release is granted in its first cycle.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared types and default widths for the unified memory port arbiter.
package proc_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 64;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data-stage and memory-side signals of the shared memory port.
interface mem_port_arbiter_if
    import proc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_if;
    logic              stall_dm;

    // Requesters and the memory array drive this side
    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_dm
    );

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_dm
    );

endinterface

// File: rtl/mem_lat_timer.sv
// Counts the fixed memory read latency of the outstanding access; done marks the completion cycle.
module mem_lat_timer #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAT_END = CW'(MEM_LAT);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [CW-1:0] lat_cnt;

    // Zero means no access in flight; a completion without a reload parks the counter at zero
    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_cnt <= '0;
        end else if (load) begin
            lat_cnt <= ONE;
        end else if (lat_cnt == LAT_END) begin
            lat_cnt <= '0;
        end else if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt + ONE;
        end
    end

    assign done = (lat_cnt == LAT_END);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and data stages: data priority, bounded fetch starvation.
module mem_port_arbiter
    import proc_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [DATA_W-1:0] DATA_ZERO = '0;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          lat_done, done, window, starve_full, if_win, dm_win;

    mem_lat_timer #(.MEM_LAT(MEM_LAT)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (if_win | dm_win),
        .done  (lat_done)
    );

    // A grant may overlap the completion cycle, giving one access every MEM_LAT cycles
    assign done        = (state_q == BUSY) & lat_done;
    assign window      = reset & ((state_q == IDLE) | done);
    assign starve_full = (starve_q == STARVE_SAT);
    assign if_win      = window & bus.if_req & (starve_full | ~bus.dm_req);
    assign dm_win      = window & bus.dm_req & ~(starve_full & bus.if_req);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        if (if_win) begin
            state_d  = BUSY;
            owner_d  = OWN_IF;
            starve_d = '0;
        end else if (dm_win) begin
            state_d = BUSY;
            owner_d = OWN_DM;
            if (bus.if_req && !starve_full) starve_d = starve_q + SW'(1);
        end else if (done) begin
            state_d = IDLE;
        end
    end

    // Every output is gated by reset so nothing leaks out of an abandoned transaction
    always_comb begin
        bus.if_gnt    = if_win;
        bus.dm_gnt    = dm_win;
        bus.mem_en    = if_win | dm_win;
        bus.mem_we    = dm_win & bus.dm_we;
        bus.mem_addr  = ADDR_ZERO;
        bus.mem_wdata = DATA_ZERO;
        if (if_win) begin
            bus.mem_addr = bus.if_addr;
        end else if (dm_win) begin
            bus.mem_addr  = bus.dm_addr;
            bus.mem_wdata = bus.dm_wdata;
        end
        bus.if_rvalid = reset & done & (owner_q == OWN_IF);
        bus.dm_rvalid = reset & done & (owner_q == OWN_DM);
        bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : DATA_ZERO;
        bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : DATA_ZERO;
        bus.stall_if  = reset & ((bus.if_req & ~if_win) |
                        ((state_q == BUSY) & (owner_q == OWN_IF) & ~bus.if_rvalid));
        bus.stall_dm  = reset & ((bus.dm_req & ~dm_win) |
                        ((state_q == BUSY) & (owner_q == OWN_DM) & ~bus.dm_rvalid));
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter with a fixed-latency memory model and per-requester scoreboards.
module tb_mem_port_arbiter;
    import proc_pkg::*;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int MEM_LAT = 2;
    localparam int STARVE_MAX = 4;

    typedef struct packed {
        logic              wr;
        logic [DATA_W-1:0] data;
    } sb_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int compared = 0;
    int mismatched = 0;
    sb_t if_q[$];
    sb_t dm_q[$];
    sb_t e_if, e_dm;
    logic [DATA_W-1:0] rd_p1 = '0, rd_p2 = '0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [DATA_W-1:0] mem_read(input logic [ADDR_W-1:0] a);
        if (a == 64'h0) return 64'h0000_0013;
        return {~a[31:0], a[31:0] ^ 32'h5A5A_0000};
    endfunction

    // Memory: data appears MEM_LAT (=2) cycles after the mem_en cycle
    always @(posedge clk) begin
        rd_p1 <= (bus.mem_en && !bus.mem_we) ? mem_read(bus.mem_addr) : '0;
        rd_p2 <= rd_p1;
    end
    assign bus.mem_rdata = rd_p2;

    always @(negedge clk) begin
        if (reset && bus.if_rvalid) begin
            compared++;
            if (if_q.size() == 0) begin
                mismatched++;
                $display("FAIL if_rvalid_unexpected: got rvalid with rdata %0h, required no response", bus.if_rdata);
            end else begin
                e_if = if_q.pop_front();
                if (bus.if_rdata !== e_if.data) begin
                    mismatched++;
                    $display("FAIL if_rdata: got %0h required %0h", bus.if_rdata, e_if.data);
                end
            end
        end
        if (reset && bus.dm_rvalid) begin
            compared++;
            if (dm_q.size() == 0) begin
                mismatched++;
                $display("FAIL dm_rvalid_unexpected: got rvalid with rdata %0h, required no response", bus.dm_rdata);
            end else begin
                e_dm = dm_q.pop_front();
                if (!e_dm.wr && bus.dm_rdata !== e_dm.data) begin
                    mismatched++;
                    $display("FAIL dm_rdata: got %0h required %0h", bus.dm_rdata, e_dm.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    endtask

    // Leaves the bench at the drive point of cycle 0, the first cycle after release
    task automatic do_reset();
        reset = 1'b0;
        clear_in();
        tick();
        tick();
        reset = 1'b1;
        if_q.delete();
        dm_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 64'h40;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 64'h100; bus.dm_wdata = 64'h1234;
        tick();
        @(negedge clk);
        compared++;
        if ({bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.mem_we, bus.stall_if, bus.stall_dm} !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl_outputs: got %b required 000000",
                     {bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.mem_we, bus.stall_if, bus.stall_dm});
        end
        compared++;
        if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata, bus.if_rvalid, bus.dm_rvalid} !== '0) begin
            mismatched++;
            $display("FAIL reset_data_outputs: got addr %0h wdata %0h required all zero", bus.mem_addr, bus.mem_wdata);
        end
        do_reset();
    endtask

    task automatic test_if_read();
        do_reset();
        tick();
        bus.if_req = 1'b1; bus.if_addr = 64'h0;
        if_q.push_back('{wr: 1'b0, data: 64'h0000_0013});
        @(negedge clk);
        compared++;
        if ({bus.if_gnt, bus.mem_en, bus.dm_gnt} !== 3'b110) begin
            mismatched++;
            $display("FAIL if_read_grant: got if_gnt,mem_en,dm_gnt=%b required 110", {bus.if_gnt, bus.mem_en, bus.dm_gnt});
        end
        compared++;
        if (bus.mem_addr !== 64'h0 || bus.mem_we !== 1'b0) begin
            mismatched++;
            $display("FAIL if_read_addr: got addr %0h we %b required 0 0", bus.mem_addr, bus.mem_we);
        end
        tick();
        bus.if_req = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.stall_if !== 1'b1 || bus.if_rvalid !== 1'b0 || bus.mem_en !== 1'b0) begin
            mismatched++;
            $display("FAIL if_read_wait: got stall_if %b rvalid %b mem_en %b required 1 0 0",
                     bus.stall_if, bus.if_rvalid, bus.mem_en);
        end
        tick();
        @(negedge clk);
        compared++;
        if (bus.if_rvalid !== 1'b1 || bus.stall_if !== 1'b0 || bus.dm_rvalid !== 1'b0) begin
            mismatched++;
            $display("FAIL if_read_done: got if_rvalid %b stall_if %b dm_rvalid %b required 1 0 0",
                     bus.if_rvalid, bus.stall_if, bus.dm_rvalid);
        end
        tick();
        @(negedge clk);
        compared++;
        if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== '0) begin
            mismatched++;
            $display("FAIL if_read_idle: got rvalid %b rdata %0h required 0 0", bus.if_rvalid, bus.if_rdata);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        tick();
        bus.if_req = 1'b1; bus.if_addr = 64'h40;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 64'h100;
        dm_q.push_back('{wr: 1'b0, data: mem_read(64'h100)});
        if_q.push_back('{wr: 1'b0, data: mem_read(64'h40)});
        @(negedge clk);
        compared++;
        if ({bus.dm_gnt, bus.if_gnt, bus.stall_if, bus.stall_dm} !== 4'b1010 || bus.mem_addr !== 64'h100) begin
            mismatched++;
            $display("FAIL simul_c1: got dm_gnt,if_gnt,stall_if,stall_dm=%b addr %0h required 1010 100",
                     {bus.dm_gnt, bus.if_gnt, bus.stall_if, bus.stall_dm}, bus.mem_addr);
        end
        tick();
        bus.dm_req = 1'b0;
        @(negedge clk);
        compared++;
        if ({bus.if_gnt, bus.stall_if, bus.stall_dm} !== 3'b011) begin
            mismatched++;
            $display("FAIL simul_c2: got if_gnt,stall_if,stall_dm=%b required 011",
                     {bus.if_gnt, bus.stall_if, bus.stall_dm});
        end
        tick();
        @(negedge clk);
        compared++;
        if ({bus.dm_rvalid, bus.if_gnt, bus.stall_dm} !== 3'b110 || bus.mem_addr !== 64'h40) begin
            mismatched++;
            $display("FAIL simul_c3: got dm_rvalid,if_gnt,stall_dm=%b addr %0h required 110 40",
                     {bus.dm_rvalid, bus.if_gnt, bus.stall_dm}, bus.mem_addr);
        end
        tick();
        bus.if_req = 1'b0;
        tick();
        @(negedge clk);
        compared++;
        if (bus.if_rvalid !== 1'b1) begin
            mismatched++;
            $display("FAIL simul_c5: got if_rvalid %b required 1", bus.if_rvalid);
        end
        tick();
    endtask

    task automatic test_starvation();
        logic exp_dm, exp_if;
        do_reset();
        tick();
        bus.if_req = 1'b1; bus.if_addr = 64'h80;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 64'h180;
        for (int c = 1; c <= 11; c++) begin
            exp_dm = (c == 1 || c == 3 || c == 5 || c == 7 || c == 11);
            exp_if = (c == 9);
            if (exp_dm) dm_q.push_back('{wr: 1'b0, data: mem_read(64'h180)});
            if (exp_if) if_q.push_back('{wr: 1'b0, data: mem_read(64'h80)});
            @(negedge clk);
            compared++;
            if (bus.dm_gnt !== exp_dm || bus.if_gnt !== exp_if) begin
                mismatched++;
                $display("FAIL starve_c%0d: got dm_gnt %b if_gnt %b required %b %b",
                         c, bus.dm_gnt, bus.if_gnt, exp_dm, exp_if);
            end
            tick();
        end
        clear_in();
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] addrs [3];
        logic exp_g, exp_v;
        int k;
        addrs[0] = 64'h0; addrs[1] = 64'h4; addrs[2] = 64'h8;
        do_reset();
        tick();
        k = 0;
        bus.if_req = 1'b1; bus.if_addr = addrs[0];
        for (int i = 0; i < 3; i++) if_q.push_back('{wr: 1'b0, data: mem_read(addrs[i])});
        for (int c = 1; c <= 7; c++) begin
            exp_g = (c == 1 || c == 3 || c == 5);
            exp_v = (c == 3 || c == 5 || c == 7);
            @(negedge clk);
            compared++;
            if (bus.if_gnt !== exp_g || bus.if_rvalid !== exp_v || (exp_g && bus.mem_addr !== addrs[k])) begin
                mismatched++;
                $display("FAIL b2b_c%0d: got if_gnt %b if_rvalid %b addr %0h required %b %b %0h",
                         c, bus.if_gnt, bus.if_rvalid, bus.mem_addr, exp_g, exp_v, addrs[k]);
            end
            tick();
            if (exp_g) begin
                k++;
                if (k < 3) bus.if_addr = addrs[k];
                else bus.if_req = 1'b0;
            end
        end
        clear_in();
    endtask

    task automatic test_write_abandon();
        do_reset();
        tick();
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 64'h200; bus.dm_wdata = 64'hDEAD_BEEF;
        dm_q.push_back('{wr: 1'b1, data: '0});
        @(negedge clk);
        compared++;
        if ({bus.dm_gnt, bus.mem_en, bus.mem_we} !== 3'b111 || bus.mem_addr !== 64'h200 ||
            bus.mem_wdata !== 64'hDEAD_BEEF) begin
            mismatched++;
            $display("FAIL write_c1: got gnt,en,we=%b addr %0h wdata %0h required 111 200 deadbeef",
                     {bus.dm_gnt, bus.mem_en, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        clear_in();
        bus.if_req = 1'b1; bus.if_addr = 64'h300;
        @(negedge clk);
        compared++;
        if ({bus.if_gnt, bus.mem_en, bus.stall_if, bus.stall_dm} !== 4'b0011) begin
            mismatched++;
            $display("FAIL abandon_c2: got if_gnt,mem_en,stall_if,stall_dm=%b required 0011",
                     {bus.if_gnt, bus.mem_en, bus.stall_if, bus.stall_dm});
        end
        tick();
        bus.if_req = 1'b0;
        for (int c = 3; c <= 4; c++) begin
            @(negedge clk);
            compared++;
            if (bus.if_gnt !== 1'b0 || bus.mem_en !== 1'b0 || bus.dm_rvalid !== (c == 3)) begin
                mismatched++;
                $display("FAIL abandon_c%0d: got if_gnt %b mem_en %b dm_rvalid %b required 0 0 %b",
                         c, bus.if_gnt, bus.mem_en, bus.dm_rvalid, (c == 3));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick();
        bus.if_req = 1'b1; bus.if_addr = 64'h80;
        @(negedge clk);
        compared++;
        if (bus.if_gnt !== 1'b1) begin
            mismatched++;
            $display("FAIL rstmid_c1: got if_gnt %b required 1", bus.if_gnt);
        end
        tick();
        bus.if_req = 1'b0;
        reset = 1'b0;
        for (int c = 2; c <= 3; c++) begin
            if (c == 3) begin bus.if_req = 1'b1; bus.if_addr = 64'h88; end
            @(negedge clk);
            compared++;
            if ({bus.if_gnt, bus.if_rvalid, bus.dm_gnt, bus.dm_rvalid, bus.mem_en, bus.stall_if,
                 bus.stall_dm, bus.mem_addr, bus.if_rdata} !== '0) begin
                mismatched++;
                $display("FAIL rstmid_c%0d: got if_gnt %b if_rvalid %b mem_en %b stall_if %b required all 0",
                         c, bus.if_gnt, bus.if_rvalid, bus.mem_en, bus.stall_if);
            end
            tick();
        end
        reset = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 64'h90;
        if_q.push_back('{wr: 1'b0, data: mem_read(64'h90)});
        @(negedge clk);
        compared++;
        if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 64'h90) begin
            mismatched++;
            $display("FAIL rstmid_release: got if_gnt %b addr %0h required 1 90", bus.if_gnt, bus.mem_addr);
        end
        tick();
        bus.if_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_drain();
        clear_in();
        tick();
        tick();
        compared++;
        if (if_q.size() != 0 || dm_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d if and %0d dm responses outstanding required 0 0",
                     if_q.size(), dm_q.size());
        end
    endtask

    initial begin
        clear_in();
        test_reset();
        test_if_read();
        test_drain();
        test_simultaneous();
        test_drain();
        test_starvation();
        test_drain();
        test_back_to_back();
        test_drain();
        test_write_abandon();
        test_drain();
        test_reset_mid();
        test_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
